ram_arbiter_8bit: RTL and testbench
===================================

Name: ram_arbiter_8bit

Overview:
Two-port round-robin arbiter and sequencer for the shared 256x8 single-port synchronous RAM. Two requesters (e.g. CPU core and a DMA/IO engine) issue read or write transactions with a req/ack handshake. The arbiter serialises the transactions onto the RAM's we/addr/data_in pins and returns read data to the winning port. It sits between the bus masters and the RAM instance; the RAM has 1-cycle synchronous read latency.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req0  in  1  port 0 transaction request, held high until ack0
we0  in  1  port 0: 1=write, 0=read; stable while req0 high
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 completion, 1-cycle pulse
rdata0  out  DATA_W  port 0 read data, valid with ack0, held until next port-0 read
req1/we1/addr1/wdata1/ack1/rdata1  same as port 0, for port 1
busy  out  1  high while a transaction is in flight (state != IDLE)
ram_we  out  1  to RAM we
ram_addr  out  ADDR_W  to RAM addr
ram_wdata  out  DATA_W  to RAM data_in
ram_rdata  in  DATA_W  from RAM data_out

Behaviour:
- All outputs registered. Reset values: ack0=ack1=0, rdata0=rdata1=0, busy=0, ram_we=0, ram_addr=0, ram_wdata=0, state=IDLE, last_grant=1 (port 0 wins first contest).
- FSM states: IDLE, ACCESS, RESP.
- IDLE: eligible_n = req_n & ~ack_n. The ack mask stops re-granting a port whose req is still high during its ack cycle. If none eligible, stay. If one eligible, grant it. If both, grant the port != last_grant. On grant: latch grant id; load ram_addr/ram_wdata/ram_we from that port; busy<=1; go ACCESS.
- ACCESS: one cycle; RAM samples ram_we/addr/wdata at the closing edge. At that edge ram_we<=0 (no double write); go RESP.
- RESP: ram_rdata is valid for reads this cycle. At the closing edge:
  - For a read, capture rdata_g<=ram_rdata. For a write, leave rdata_g unchanged; the RAM output is Z in write mode and must not be captured.
  - ack_g<=1, last_grant<=g, busy<=0; go IDLE.
- ack pulses exactly one cycle: cleared on the next edge unconditionally.
- Latency: req sampled at edge E0 (in IDLE) -> ack high in the cycle after E2. Back-to-back throughput: one transaction per 3 cycles.
- Requester rule: drop or change req in the ack cycle. A new request may be issued from the cycle after ack.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1...
- Port inputs are sampled only at grant. Changes to addr/we/wdata after grant are ignored.
- Asynchronous rst mid-transaction: immediate return to IDLE with all reset values; no ack for the aborted transaction. A partially issued write may or may not have landed; rst also clears the RAM.
- No address range checks; full 0..255 space, no wrap logic needed.

Decomposition:
- Shared package ram_arb_pkg: state encoding localparams (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), ADDR_W/DATA_W defaults.
- One natural sub-module: rr_arb2. Combinational 2-way round-robin pick from eligible[1:0] and last_grant, producing grant_valid and grant_id. The FSM and datapath registers stay in the top.

Test Plan:
- Reset: assert rst mid-sim -> ack0/1=0, rdata0/1=0, ram_we=0, busy=0 within the same cycle, with no clock edge needed.
- Single write then read, port 0: write addr=8'h3C data=8'hA5, wait ack0; read addr=8'h3C -> ack0 exactly 3 cycles after req sampled, rdata0=8'hA5, ram_we high for exactly one cycle during the write.
- Simultaneous requests after reset: req0 reads 8'h10, req1 writes 8'h10=8'h5A in the same cycle -> port 0 served first (returns reset value 8'h00), then port 1; a following port-0 read returns 8'h5A.
- Fairness: both reqs held high for 6 transactions -> grant order 0,1,0,1,0,1; no ack ever coincides on both ports.
- Write preserves rdata: port 1 reads 8'h77 from addr 8'h01, then writes addr 8'h02 -> rdata1 stays 8'h77 after the write ack, never X/Z.
- Reset during ACCESS: rst pulsed while busy=1 -> no ack for that transaction; a subsequent read of the same address returns 8'h00.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths and the
// sequencer state encoding.
package ram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // IDLE waits for a request, ACCESS drives the RAM pins for one cycle,
  // RESP is the cycle in which the RAM's synchronous read data is valid.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Port identifiers used for grant bookkeeping.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage : ram_arb_pkg

// File: rtl/ram_arbiter_8bit_rr_arb2.sv
// Combinational two-way round-robin pick. When both ports are eligible the
// one that was not granted last wins; a lone eligible port always wins.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // Pick the winner from the eligibility vector and the previous grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = PORT0;
    unique case (eligible)
      2'b01: begin
        grant_valid = 1'b1;
        grant_id    = PORT0;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_id    = PORT1;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end
      default: begin
        grant_valid = 1'b0;
        grant_id    = PORT0;
      end
    endcase
  end

endmodule : rr_arb2

// File: rtl/ram_arbiter_8bit.sv
// Two-port round-robin arbiter and sequencer in front of a shared single-port
// synchronous RAM (1-cycle read latency). Each transaction takes three
// cycles: grant (IDLE), pin drive (ACCESS), data return (RESP), and the
// requester sees a one-cycle ack with read data in the cycle after RESP.
module ram_arbiter_8bit
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // port 0
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  // port 1
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  // status
  output logic              busy,
  // RAM side
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t state_reg;
  logic   grant_reg;       // port owning the transaction in flight
  logic   op_we_reg;       // direction of the transaction in flight
  logic   last_grant_reg;  // port served most recently

  logic [1:0]        eligible;
  logic              grant_valid;
  logic              grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A port whose ack is showing this cycle is masked so a req still held
  // during its ack cycle is not granted a second time.
  assign eligible = {req1 & ~ack1, req0 & ~ack0};

  rr_arb2 u_rr_arb2 (
    .eligible    (eligible),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Route the winning port's request fields to the RAM pin loaders.
  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (grant_id == PORT1) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= PORT0;
      op_we_reg      <= 1'b0;
      last_grant_reg <= PORT1;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      rdata0         <= '0;
      rdata1         <= '0;
      busy           <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
    end else begin
      // Acks are single-cycle pulses; RESP re-asserts one below.
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            grant_reg <= grant_id;
            op_we_reg <= sel_we;
            ram_we    <= sel_we;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            busy      <= 1'b1;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          // The RAM samples the pins at this edge; drop we so it writes once.
          ram_we    <= 1'b0;
          state_reg <= RESP;
        end
        RESP: begin
          // Only reads capture: the RAM output is undriven after a write.
          if (!op_we_reg) begin
            if (grant_reg == PORT1) begin
              rdata1 <= ram_rdata;
            end else begin
              rdata0 <= ram_rdata;
            end
          end
          if (grant_reg == PORT1) begin
            ack1 <= 1'b1;
          end else begin
            ack0 <= 1'b1;
          end
          last_grant_reg <= grant_reg;
          busy           <= 1'b0;
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule : ram_arbiter_8bit

// File: tb/tb_ram_arbiter_8bit.sv
// Bench for ram_arbiter_8bit: behavioural RAM, a memory/ordering reference
// model, directed scenarios and randomized transaction pairs.
module tb_ram_arbiter_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic       ack0, ack1, busy, ram_we;
  logic [7:0] rdata0, rdata1, ram_addr, ram_wdata;
  wire  [7:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, last served port, held read data.
  logic [7:0] mdl_mem [256];
  logic       mdl_last;
  logic [7:0] mdl_rdata [2];

  always #5 clk = ~clk;

  ram_arbiter_8bit dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .busy(busy), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Behavioural 256x8 single-port RAM, cleared by rst, Z output while writing.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_q;
  logic       ram_q_z;
  assign ram_rdata = ram_q_z ? 8'hzz : ram_q;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
      ram_q   <= 8'h00;
      ram_q_z <= 1'b0;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_wdata;
      ram_q_z <= 1'b1;
    end else begin
      ram_q   <= ram_mem[ram_addr];
      ram_q_z <= 1'b0;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
    mdl_last     = 1'b1;
    mdl_rdata[0] = 8'h00;
    mdl_rdata[1] = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check every output against its reset value, with no clock edge involved.
  task automatic check_reset_outputs(input string tag);
    logic [31:0] got;
    got = {ack0, ack1, busy, ram_we, rdata0, rdata1, ram_addr, ram_wdata[3:0]};
    checks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0 ||
        rdata0 !== 8'h00 || rdata1 !== 8'h00 || ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin
      errors++;
      $display("FAIL %s: outputs ack0=%b ack1=%b busy=%b ram_we=%b rdata0=%h rdata1=%h ram_addr=%h ram_wdata=%h, required all zero",
               tag, ack0, ack1, busy, ram_we, rdata0, rdata1, ram_addr, ram_wdata);
    end
    $display("reset check %s: packed=%h", tag, got);
  endtask

  task automatic apply_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    rst  = 1'b1;
    #2;
    check_reset_outputs("reset_async");
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  // Issue one request on either or both ports, predict service order and
  // data from the model, and check acks, latency, read data and RAM writes.
  task automatic do_txn(input bit r0, input bit w0_i, input logic [7:0] a0, input logic [7:0] d0,
                        input bit r1, input bit w1_i, input logic [7:0] a1, input logic [7:0] d1);
    int         order [2];
    logic [7:0] exp_rd [2];
    bit         pw [2];
    logic [7:0] pa [2];
    logic [7:0] pd [2];
    int         n, got, we_cycles, exp_we, p;
    logic [7:0] rd;
    pw[0] = w0_i; pa[0] = a0; pd[0] = d0;
    pw[1] = w1_i; pa[1] = a1; pd[1] = d1;
    n = 0;
    if (r0 && r1) begin
      order[0] = mdl_last ? 0 : 1;
      order[1] = 1 - order[0];
      n = 2;
    end else if (r0) begin
      order[0] = 0; n = 1;
    end else if (r1) begin
      order[0] = 1; n = 1;
    end
    exp_we = 0;
    for (int k = 0; k < n; k++) begin
      p = order[k];
      if (pw[p]) begin
        mdl_mem[pa[p]] = pd[p];
        exp_we++;
      end else begin
        mdl_rdata[p] = mdl_mem[pa[p]];
      end
      exp_rd[k] = mdl_rdata[p];
      mdl_last  = p[0];
    end
    req0 = r0; we0 = w0_i; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1_i; addr1 = a1; wdata1 = d1;
    got = 0;
    we_cycles = 0;
    for (int cyc = 1; cyc <= 12 && got < n; cyc++) begin
      tick();
      if (ram_we === 1'b1) we_cycles++;
      if (ack0 === 1'b1 && ack1 === 1'b1) begin
        checks++; errors++;
        $display("FAIL dual_ack: ack0=%b ack1=%b at cycle %0d, required at most one", ack0, ack1, cyc);
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        p  = (ack1 === 1'b1) ? 1 : 0;
        rd = (p == 1) ? rdata1 : rdata0;
        checks++;
        if (p != order[got]) begin
          errors++;
          $display("FAIL grant_order: ack on port %0d, required port %0d", p, order[got]);
        end
        checks++;
        if (cyc != 3 * (got + 1)) begin
          errors++;
          $display("FAIL ack_latency: ack at cycle %0d, required cycle %0d", cyc, 3 * (got + 1));
        end
        checks++;
        if (rd !== exp_rd[got]) begin
          errors++;
          $display("FAIL rdata_port%0d: got %h, required %h", p, rd, exp_rd[got]);
        end
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_ack: got %b, required 0", busy);
        end
        $display("txn port%0d %s addr=%h data=%h at cycle %0d", p, pw[p] ? "WR" : "RD", pa[p],
                 pw[p] ? pd[p] : rd, cyc);
        if (p == 1) req1 = 1'b0; else req0 = 1'b0;
        got++;
      end
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL ack_timeout: %0d acks seen, required %0d", got, n);
    end
    checks++;
    if (we_cycles != exp_we) begin
      errors++;
      $display("FAIL ram_we_cycles: got %0d, required %0d", we_cycles, exp_we);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    do_txn(1, 1, 8'h20, 8'hAA, 0, 0, 8'h00, 8'h00);
    do_txn(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid_sim");
    tick();
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_write_read();
    do_txn(1, 1, 8'h3C, 8'hA5, 0, 0, 8'h00, 8'h00);
    do_txn(1, 0, 8'h3C, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++;
    if (rdata0 !== 8'hA5) begin
      errors++;
      $display("FAIL write_read: rdata0=%h, required a5", rdata0);
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    do_txn(1, 0, 8'h10, 8'h00, 1, 1, 8'h10, 8'h5A);
    do_txn(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    checks++;
    if (rdata0 !== 8'h5A) begin
      errors++;
      $display("FAIL simultaneous_followup: rdata0=%h, required 5a", rdata0);
    end
  endtask

  // Both reqs held high throughout; acks must alternate every three cycles.
  task automatic test_fairness();
    int         acks, p, cyc;
    logic [7:0] rd, exp;
    apply_reset();
    mdl_mem[8'h05] = 8'h00;
    do_txn(1, 1, 8'h05, 8'h31, 1, 1, 8'h06, 8'h42);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h05;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h06;
    acks = 0;
    cyc  = 0;
    while (acks < 6 && cyc < 40) begin
      tick();
      cyc++;
      if (ack0 === 1'b1 && ack1 === 1'b1) begin
        checks++; errors++;
        $display("FAIL fair_dual_ack: both acks at cycle %0d", cyc);
      end
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        p   = (ack1 === 1'b1) ? 1 : 0;
        rd  = (p == 1) ? rdata1 : rdata0;
        exp = (p == 1) ? 8'h42 : 8'h31;
        checks++;
        if (p != (acks % 2) || cyc != 3 * (acks + 1)) begin
          errors++;
          $display("FAIL fair_order: ack %0d on port %0d at cycle %0d, required port %0d at cycle %0d",
                   acks, p, cyc, acks % 2, 3 * (acks + 1));
        end
        checks++;
        if (rd !== exp) begin
          errors++;
          $display("FAIL fair_rdata: port %0d got %h, required %h", p, rd, exp);
        end
        $display("txn fair port%0d RD data=%h at cycle %0d", p, rd, cyc);
        acks++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checks++;
    if (acks != 6) begin
      errors++;
      $display("FAIL fair_timeout: %0d acks, required 6", acks);
    end
    mdl_rdata[0] = 8'h31;
    mdl_rdata[1] = 8'h42;
    mdl_last     = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_write_preserves();
    do_txn(1, 1, 8'h01, 8'h77, 0, 0, 8'h00, 8'h00);
    do_txn(0, 0, 8'h00, 8'h00, 1, 0, 8'h01, 8'h00);
    do_txn(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h3E);
    checks++;
    if (rdata1 !== 8'h77) begin
      errors++;
      $display("FAIL write_preserves: rdata1=%h, required 77", rdata1);
    end
  endtask

  task automatic test_reset_access();
    int ack_seen;
    apply_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h44; wdata0 = 8'h99;
    tick();
    checks++;
    if (busy !== 1'b1 || ram_we !== 1'b1) begin
      errors++;
      $display("FAIL access_state: busy=%b ram_we=%b, required 1 1", busy, ram_we);
    end
    #2;
    rst  = 1'b1;
    req0 = 1'b0;
    #1;
    check_reset_outputs("reset_in_access");
    ack_seen = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (ack0 === 1'b1 || ack1 === 1'b1) ack_seen++;
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack0 === 1'b1 || ack1 === 1'b1) ack_seen++;
    end
    checks++;
    if (ack_seen != 0) begin
      errors++;
      $display("FAIL aborted_ack: %0d acks after reset, required 0", ack_seen);
    end
    do_txn(1, 0, 8'h44, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    int mode;
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(1, 3);
      do_txn(mode[0], $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)), 8'($urandom),
             mode[1], $urandom_range(0, 1) == 1, 8'($urandom_range(0, 7)), 8'($urandom));
    end
  endtask

  initial begin
    model_reset();
    #2;
    check_reset_outputs("reset_initial");
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_write_read();
    test_reset();
    test_simultaneous();
    test_fairness();
    test_write_preserves();
    test_reset_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_arbiter_8bit
